// File: rtl/vrf_pkg.sv
// Shared vector register file types and sizes, imported by the datapath and the
// register file alike.
package vrf_pkg;
  localparam int unsigned NREG    = 32;
  localparam int unsigned VLEN    = 128;
  localparam int unsigned VLENB   = VLEN / 8;
  localparam int unsigned VREG_AW = 5;

  typedef logic [VLEN-1:0]    vreg_t;
  typedef logic [VREG_AW-1:0] vaddr_t;
  typedef logic [VLENB-1:0]   vstrb_t;
endpackage

// File: rtl/vrf_wmerge.sv
// Next-state byte merge for one vector register: applies every write port that
// targets this register, highest port winning per byte, and flags byte overlaps.
module vrf_wmerge
  import vrf_pkg::*;
#(
  parameter int unsigned NWR     = 4,
  parameter int unsigned REG_IDX = 0
) (
  input  vreg_t                cur,
  input  vaddr_t [NWR-1:0]     waddr,
  input  vstrb_t [NWR-1:0]     wstrb,
  input  vreg_t  [NWR-1:0]     wdata,
  output vreg_t                nxt_c,
  output logic                 conflict_c
);

  // Ascending port scan: a later port overwrites the byte, so the highest port wins.
  always_comb begin
    logic [VLENB-1:0] hit;
    hit        = '0;
    nxt_c      = cur;
    conflict_c = 1'b0;
    for (int p = 0; p < int'(NWR); p++) begin
      if (waddr[p] == VREG_AW'(REG_IDX)) begin
        for (int b = 0; b < int'(VLENB); b++) begin
          if (wstrb[p][b]) begin
            if (hit[b]) conflict_c = 1'b1;
            hit[b]           = 1'b1;
            nxt_c[b*8 +: 8]  = wdata[p][b*8 +: 8];
          end
        end
      end
    end
  end

endmodule

// File: rtl/vector_regfile.sv
// 32 x 128-bit vector register file: eight registered read ports fed from the
// array's next state (write-first), four byte-strobed write ports.
module vector_regfile #(
  parameter int unsigned NREG = vrf_pkg::NREG,
  parameter int unsigned VLEN = vrf_pkg::VLEN,
  parameter int unsigned NRD  = 8,
  parameter int unsigned NWR  = 4
) (
  input  logic                              vsi_clk,
  input  logic                              vsi_rst,
  input  logic [NRD-1:0][$clog2(NREG)-1:0]  vsi_rf_raddr,
  output logic [NRD-1:0][VLEN-1:0]          vsi_rf_rdata,
  input  logic [NWR-1:0][$clog2(NREG)-1:0]  vsi_rf_waddr,
  input  logic [NWR-1:0][VLEN/8-1:0]        vsi_rf_wstrb,
  input  logic [NWR-1:0][VLEN-1:0]          vsi_rf_wdata,
  output logic                              vsi_rf_wconflict
);

  logic [VLEN-1:0] regs  [NREG];
  logic [VLEN-1:0] nxt_c [NREG];
  logic [NREG-1:0] conf_c;

  for (genvar r = 0; r < int'(NREG); r++) begin : g_merge
    vrf_wmerge #(
      .NWR     (NWR),
      .REG_IDX (r)
    ) u_wmerge (
      .cur        (regs[r]),
      .waddr      (vsi_rf_waddr),
      .wstrb      (vsi_rf_wstrb),
      .wdata      (vsi_rf_wdata),
      .nxt_c      (nxt_c[r]),
      .conflict_c (conf_c[r])
    );
  end

  // Read registers sample the merged next state, giving write-first reads.
  always_ff @(posedge vsi_clk) begin
    if (vsi_rst) begin
      for (int r = 0; r < int'(NREG); r++) regs[r] <= '0;
      vsi_rf_rdata     <= '0;
      vsi_rf_wconflict <= 1'b0;
    end else begin
      for (int r = 0; r < int'(NREG); r++) regs[r] <= nxt_c[r];
      for (int i = 0; i < int'(NRD); i++) vsi_rf_rdata[i] <= nxt_c[vsi_rf_raddr[i]];
      vsi_rf_wconflict <= |conf_c;
    end
  end

endmodule

// File: tb/tb_vector_regfile.sv
// Randomized and directed bench for vector_regfile against a behavioural
// register-array model.
module tb_vector_regfile;

  logic                clk;
  logic                rst;
  logic [7:0][4:0]     raddr;
  logic [7:0][127:0]   rdata;
  logic [3:0][4:0]     waddr;
  logic [3:0][15:0]    wstrb;
  logic [3:0][127:0]   wdata;
  logic                wconflict;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  logic [127:0]      mem   [32];
  logic [127:0]      nm    [32];
  int                cnt   [32][16];
  logic [7:0][127:0] exp_rd = '0;
  logic              exp_cf = 1'b0;

  localparam logic [127:0] V5   = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  localparam logic [127:0] ONES = {128{1'b1}};

  vector_regfile dut (
    .vsi_clk          (clk),
    .vsi_rst          (rst),
    .vsi_rf_raddr     (raddr),
    .vsi_rf_rdata     (rdata),
    .vsi_rf_waddr     (waddr),
    .vsi_rf_wstrb     (wstrb),
    .vsi_rf_wdata     (wdata),
    .vsi_rf_wconflict (wconflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: apply strobed bytes port by port in ascending order, count hits per byte.
  always @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < 32; r++) mem[r] = '0;
      exp_rd = '0;
      exp_cf = 1'b0;
    end else begin
      for (int r = 0; r < 32; r++) begin
        nm[r] = mem[r];
        for (int b = 0; b < 16; b++) cnt[r][b] = 0;
      end
      for (int p = 0; p < 4; p++)
        for (int b = 0; b < 16; b++)
          if (wstrb[p][b]) begin
            cnt[waddr[p]][b] = cnt[waddr[p]][b] + 1;
            nm[waddr[p]][b*8 +: 8] = wdata[p][b*8 +: 8];
          end
      exp_cf = 1'b0;
      for (int r = 0; r < 32; r++) begin
        mem[r] = nm[r];
        for (int b = 0; b < 16; b++) if (cnt[r][b] >= 2) exp_cf = 1'b1;
      end
      for (int i = 0; i < 8; i++) exp_rd[i] = mem[raddr[i]];
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rdata[i] !== exp_rd[i]) begin
          errors++;
          $display("FAIL model_rdata[%0d] got %h exp %h at %0t", i, rdata[i], exp_rd[i], $time);
        end
      end
      checks++;
      if (wconflict !== exp_cf) begin
        errors++;
        $display("FAIL model_wconflict got %b exp %b at %0t", wconflict, exp_cf, $time);
      end
    end
  end

  task automatic lit(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, act, exp);
    end
  endtask

  task automatic idle();
    raddr = '0;
    waddr = '0;
    wstrb = '0;
    wdata = '0;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    step();
    chk_en = 1;
    rst = 1'b0;

    // Reset contents: read every register once.
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int i = 0; i < 8; i++) raddr[i] = 5'(c*8 + i);
      step();
      for (int i = 0; i < 8; i++) lit("reset_rdata", rdata[i], '0);
      lit("reset_wconflict", 128'(wconflict), '0);
    end

    idle();
    waddr[0] = 5'd5; wstrb[0] = 16'hFFFF; wdata[0] = V5; raddr[3] = 5'd5;
    step();
    lit("write_first_v5", rdata[3], V5);

    idle();
    waddr[1] = 5'd7; wstrb[1] = 16'h00FF; wdata[1] = {16{8'hAA}};
    waddr[2] = 5'd7; wstrb[2] = 16'hFF00; wdata[2] = {16{8'h55}};
    raddr[0] = 5'd7;
    step();
    lit("disjoint_merge_v7", rdata[0], {{8{8'h55}}, {8{8'hAA}}});
    lit("disjoint_no_conflict", 128'(wconflict), '0);

    idle();
    waddr[0] = 5'd9; wstrb[0] = 16'h0001; wdata[0] = 128'h11;
    waddr[3] = 5'd9; wstrb[3] = 16'h0001; wdata[3] = 128'h33;
    raddr[0] = 5'd9;
    step();
    lit("collision_winner_v9", 128'(rdata[0][7:0]), 128'h33);
    lit("collision_flag", 128'(wconflict), 128'd1);
    idle();
    step();
    lit("collision_flag_pulse", 128'(wconflict), '0);

    idle();
    waddr[0] = 5'd2; wstrb[0] = 16'hFFFF; wdata[0] = ONES;
    step();
    idle();
    rst = 1'b1;
    waddr[0] = 5'd3; wstrb[0] = 16'hFFFF; wdata[0] = ONES;
    step();
    rst = 1'b0;
    idle();
    raddr[0] = 5'd2; raddr[1] = 5'd3;
    step();
    lit("reset_clears_v2", rdata[0], '0);
    lit("reset_drops_v3", rdata[1], '0);

    idle();
    waddr[0] = 5'd31; wstrb[0] = 16'h0000; wdata[0] = ONES; raddr[0] = 5'd31;
    step();
    lit("zero_strobe_v31", rdata[0], '0);
    lit("zero_strobe_no_conflict", 128'(wconflict), '0);

    // Random traffic over a narrow address window to provoke collisions.
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 79) == 0);
      for (int p = 0; p < 4; p++) begin
        waddr[p] = 5'($urandom_range(0, 7));
        case ($urandom_range(0, 3))
          0: wstrb[p] = 16'h0000;
          1: wstrb[p] = 16'hFFFF;
          default: wstrb[p] = 16'($urandom);
        endcase
        wdata[p] = {$urandom, $urandom, $urandom, $urandom};
      end
      for (int i = 0; i < 8; i++)
        raddr[i] = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 7));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_regfile.md
# vector_regfile

Vector register file serving the vector coprocessor datapath: 32 architectural registers of 128 bits, eight read ports and four byte-strobed write ports. It is the responder end of the datapath's `vsi_rf_*` read/write interface: it samples read addresses and returns registered data one cycle later, and merges up to four strobed writes per cycle. It also flags same-cycle write collisions to the same byte.

## Interface
Parameters:
- `NREG`, 32, number of vector registers (address width `$clog2(NREG)` = 5)
- `VLEN`, 128, register width in bits; `VLEN/8` = 16 byte lanes
- `NRD`, 8, read ports
- `NWR`, 4, write ports

Ports:
- `vsi_clk`  input  1  sole clock; all state updates on rising edge
- `vsi_rst`  input  1  reset, synchronous, active-high
- `vsi_rf_raddr`  input  [NRD-1:0][4:0]  read address per port, sampled every cycle
- `vsi_rf_rdata`  output  [NRD-1:0][VLEN-1:0]  registered read data
- `vsi_rf_waddr`  input  [NWR-1:0][4:0]  write address per port
- `vsi_rf_wstrb`  input  [NWR-1:0][VLEN/8-1:0]  byte strobes; all-zero = port idle
- `vsi_rf_wdata`  input  [NWR-1:0][VLEN-1:0]  write data
- `vsi_rf_wconflict`  output  1  registered pulse: ≥2 ports strobed the same byte of the same register last cycle

## Operation
- Storage: `NREG` × `VLEN` flop array; no hardwired register (v0 is ordinary storage).
- Write: on each edge, for each register r and byte b, byte updates if any port p has `waddr[p]==r` and `wstrb[p][b]==1`. No separate write enable; strobes alone qualify.
- Collision: multiple ports hitting same (r,b) → highest-numbered port wins for that byte; others dropped for that byte only. Non-overlapping bytes from different ports to the same register all land.
- `vsi_rf_wconflict` asserts for one cycle after any overlapping (r,b); disjoint strobes to the same register are not a conflict.
- Read: each port independent; any address legal; multiple ports may read the same register.
- Read is write-first: data returned for an address sampled at edge N reflects all writes committed at edge N (merged bytes, collision winner applied). Implemented as array-next-state feeding read registers, not a separate bypass mux per port pair.
- Address width is exactly 5 bits for NREG=32; no out-of-range case exists.
- Reset (`vsi_rst` high at an edge): all registers ← 0, all `vsi_rf_rdata` ← 0, `vsi_rf_wconflict` ← 0. Writes and reads presented in a reset cycle are discarded. Reset asserted mid-burst takes effect at that edge with no partial commit.

## Timing
- Read latency: 1 cycle. `raddr` at edge N → `rdata` valid after edge N, held until edge N+1.
- Write latency: 1 cycle; visible on a read sampled the same edge (write-first) and all later ones.
- Back-to-back writes to the same register every cycle supported; no stalls, no backpressure, no busy output.
- `vsi_rf_wconflict` aligned with the read data of the same edge (1 cycle after the colliding writes).
- First cycle after reset deassertion: `rdata` = 0; a read issued in it returns 0 unless written at that edge.
- All outputs registered; no combinational input→output path.

## Structure
- Shared package `vrf_pkg`: `NREG`, `VLEN`, `VLENB` (=VLEN/8), `VREG_AW` (=5); typedefs `vreg_t` (logic [VLEN-1:0]), `vaddr_t` (logic [4:0]), `vstrb_t` (logic [VLENB-1:0]). Datapath imports the same types.
- One sub-module `vrf_wmerge`: per-register combinational byte-merge of NWR ports with priority and per-byte collision detect; instantiated NREG times; top ORs collision bits and holds array/read/flag registers.

## Test plan
- Reset then read all 32 registers via 8 ports over 4 cycles → every `rdata` = 0, `wconflict` = 0.
- Port 0 writes v5 = 128'h00112233_44556677_8899AABB_CCDDEEFF, strb 16'hFFFF, port 3 reads v5 same edge → next cycle port 3 `rdata` = that value (write-first).
- Port 1 writes v7 strb 16'h00FF data all 0xAA; port 2 writes v7 strb 16'hFF00 data all 0x55 same cycle → v7 = {8{8'h55},8{8'hAA}}, `wconflict` = 0.
- Port 0 and port 3 both write v9 strb 16'h0001, data bytes 0x11 and 0x33 → v9[7:0] = 0x33, `wconflict` = 1 for exactly one cycle.
- Write v2 = all 1s, then `vsi_rst` high one cycle concurrent with write v3 = all 1s → reads of v2 and v3 after reset return 0.
- Write v31 with strb 16'h0000 data all 1s → v31 unchanged (0), no conflict.
